// File: rtl/timer_pkg.sv
//==============================================================================
// Module   : timer_pkg
// Brief    : Shared types and the prescaler divide helper for the interval timer.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package timer_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } timer_state_e;

    typedef enum logic [0:0] {
        ONE_SHOT = 1'b0,
        PERIODIC = 1'b1
    } timer_mode_e;

    localparam int c_MIN_DIV = 2;

    // Returns 0 for a non-integer ratio so the caller's range check rejects it.
    function automatic int calc_div(input int clk_hz, input int tick_hz);
        int w_div;
        w_div = 0;
        if (tick_hz > 0) begin
            if ((clk_hz % tick_hz) == 0) begin
                w_div = clk_hz / tick_hz;
            end
        end
        return w_div;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tick_prescaler.sv
//==============================================================================
// Module   : tick_prescaler
// Brief    : Free-running 0..P_DIV-1 divider producing a one-cycle tick while enabled.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tick_prescaler #(
    parameter int P_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic iClr,
    input  logic iEn,
    output logic oTick
);

    localparam int c_PRE_W = (P_DIV > 2) ? $clog2(P_DIV) : 1;
    localparam logic [c_PRE_W-1:0] c_LAST = c_PRE_W'(P_DIV - 1);

    logic [c_PRE_W-1:0] r_pre;
    logic               w_wrap;

    assign w_wrap = (r_pre == c_LAST);

    // Disabled means parked at zero, so every run starts a full tick period.
    always_ff @(posedge clk) begin
        if (rst || iClr || !iEn) begin
            r_pre <= '0;
        end else if (w_wrap) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + 1'b1;
        end
    end

    assign oTick = iEn && w_wrap;

endmodule

`default_nettype wire

// File: rtl/timer_ctrl.sv
//==============================================================================
// Module   : timer_ctrl
// Brief    : One-shot / periodic interval timer with sticky expiry interrupt.
//            Optional overrun flag is built when TIMER_CTRL_OVERRUN_EN is defined.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module timer_ctrl
    import timer_pkg::*;
#(
    parameter int P_CLK_HZ  = 100_000_000,
    parameter int P_TICK_HZ = 1000,
    parameter int P_CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               iStart,
    input  logic               iStop,
    input  logic               iMode,
    input  logic [P_CNT_W-1:0] iPeriod,
    input  logic               iIrqAck,
    output logic               oBusy,
    output logic               oIrq,
    output logic [P_CNT_W-1:0] oCount,
    output logic               oTick
`ifdef TIMER_CTRL_OVERRUN_EN
    ,
    output logic               oOverrun
`endif
);

    localparam int c_DIV = calc_div(P_CLK_HZ, P_TICK_HZ);
    localparam logic [P_CNT_W-1:0] c_ONE = P_CNT_W'(1);

    if (c_DIV < c_MIN_DIV) begin : g_div_check
        $error("timer_ctrl: P_CLK_HZ / P_TICK_HZ must be an exact integer >= 2");
    end

    timer_state_e       r_state;
    timer_state_e       w_state_nxt;
    timer_mode_e        r_mode;
    timer_mode_e        w_mode_nxt;
    logic [P_CNT_W-1:0] r_count;
    logic [P_CNT_W-1:0] w_count_nxt;
    logic [P_CNT_W-1:0] r_period;
    logic [P_CNT_W-1:0] w_period_nxt;
    logic               r_irq;
    logic               w_tick;
    logic               w_run;
    logic               w_start_ok;
    logic               w_expire;
    logic               w_clr_pre;

    assign w_run      = (r_state == RUN);
    assign w_start_ok = iStart && (iPeriod != '0);

    tick_prescaler #(
        .P_DIV (c_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .iClr  (w_clr_pre),
        .iEn   (w_run),
        .oTick (w_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_mode   <= ONE_SHOT;
            r_count  <= '0;
            r_period <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_mode   <= w_mode_nxt;
            r_count  <= w_count_nxt;
            r_period <= w_period_nxt;
        end
    end

    // Stop beats start, start beats expiry; a restart never expires in its own cycle.
    always_comb begin
        w_state_nxt  = r_state;
        w_mode_nxt   = r_mode;
        w_count_nxt  = r_count;
        w_period_nxt = r_period;
        w_expire     = 1'b0;
        w_clr_pre    = 1'b0;
        if (iStop) begin
            w_state_nxt = IDLE;
            w_count_nxt = '0;
        end else if (w_start_ok) begin
            w_state_nxt  = RUN;
            w_mode_nxt   = timer_mode_e'(iMode);
            w_count_nxt  = iPeriod;
            w_period_nxt = iPeriod;
            w_clr_pre    = 1'b1;
        end else if (w_run && w_tick) begin
            if (r_count > c_ONE) begin
                w_count_nxt = r_count - c_ONE;
            end else begin
                w_expire = 1'b1;
                if (r_mode == PERIODIC) begin
                    w_count_nxt = r_period;
                end else begin
                    w_count_nxt = '0;
                    w_state_nxt = IDLE;
                end
            end
        end
    end

    // Expiry outranks the ack so a fresh event is never lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_irq <= 1'b0;
        end else if (w_expire) begin
            r_irq <= 1'b1;
        end else if (iIrqAck) begin
            r_irq <= 1'b0;
        end
    end

`ifdef TIMER_CTRL_OVERRUN_EN
    logic r_overrun;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_overrun <= 1'b0;
        end else if (w_expire && r_irq) begin
            r_overrun <= 1'b1;
        end else if (iIrqAck && !w_expire) begin
            r_overrun <= 1'b0;
        end
    end

    assign oOverrun = r_overrun;
`endif

    assign oBusy  = w_run;
    assign oIrq   = r_irq;
    assign oCount = r_count;
    assign oTick  = w_tick;

endmodule

`default_nettype wire

// File: tb/tb_timer_ctrl.sv
//==============================================================================
// Module   : tb_timer_ctrl
// Brief    : Scoreboard bench for timer_ctrl (P_DIV = 4, 8-bit counter).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_timer_ctrl;

    localparam int P_CLK_HZ  = 100;
    localparam int P_TICK_HZ = 25;
    localparam int P_CNT_W   = 8;

    localparam int c_BUSY  = 0;
    localparam int c_IRQ   = 1;
    localparam int c_COUNT = 2;
    localparam int c_TICK  = 3;
    localparam int c_OVR   = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               iStart;
    logic               iStop;
    logic               iMode;
    logic [P_CNT_W-1:0] iPeriod;
    logic               iIrqAck;
    logic               oBusy;
    logic               oIrq;
    logic [P_CNT_W-1:0] oCount;
    logic               oTick;
`ifdef TIMER_CTRL_OVERRUN_EN
    logic               oOverrun;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        int c;
        int sel;
        int val;
        int tid;
    } exp_t;

    exp_t q[$];

    timer_ctrl #(
        .P_CLK_HZ  (P_CLK_HZ),
        .P_TICK_HZ (P_TICK_HZ),
        .P_CNT_W   (P_CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .iStart   (iStart),
        .iStop    (iStop),
        .iMode    (iMode),
        .iPeriod  (iPeriod),
        .iIrqAck  (iIrqAck),
        .oBusy    (oBusy),
        .oIrq     (oIrq),
        .oCount   (oCount),
        .oTick    (oTick)
`ifdef TIMER_CTRL_OVERRUN_EN
        ,
        .oOverrun (oOverrun)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input int act, input int want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, want);
        end
    endtask

    function automatic int observe(input int sel);
        case (sel)
            c_BUSY:  return int'(oBusy);
            c_IRQ:   return int'(oIrq);
            c_COUNT: return int'(oCount);
            c_TICK:  return int'(oTick);
`ifdef TIMER_CTRL_OVERRUN_EN
            c_OVR:   return int'(oOverrun);
`endif
            default: return -1;
        endcase
    endfunction

    function automatic string sel_name(input int sel);
        case (sel)
            c_BUSY:  return "busy";
            c_IRQ:   return "irq";
            c_COUNT: return "count";
            c_TICK:  return "tick";
            c_OVR:   return "overrun";
            default: return "unknown";
        endcase
    endfunction

    task automatic expect_at(input int tid, input int c, input int sel, input int val);
        q.push_back('{c, sel, val, tid});
    endtask

    // Outputs are compared mid-cycle, after the edge numbered by cyc.
    always @(negedge clk) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].c == cyc) begin
                check_eq($sformatf("t%0d_%s_e%0d", q[i].tid, sel_name(q[i].sel), q[i].c),
                         observe(q[i].sel), q[i].val);
                q.delete(i);
            end else if (q[i].c < cyc) begin
                check_eq($sformatf("t%0d_%s_late", q[i].tid, sel_name(q[i].sel)), cyc, q[i].c);
                q.delete(i);
            end
        end
    end

    // Leaves the bench just after edge e-1 so the next drive is sampled at edge e.
    task automatic goto_edge(input int e);
        while (cyc < e - 1) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_at(input int e, input int period, input bit mode);
        goto_edge(e);
        iStart  = 1'b1;
        iPeriod = P_CNT_W'(period);
        iMode   = mode;
        @(posedge clk);
        #1;
        iStart  = 1'b0;
    endtask

    task automatic stop_at(input int e);
        goto_edge(e);
        iStop = 1'b1;
        @(posedge clk);
        #1;
        iStop = 1'b0;
    endtask

    task automatic ack_at(input int e);
        goto_edge(e);
        iIrqAck = 1'b1;
        @(posedge clk);
        #1;
        iIrqAck = 1'b0;
    endtask

    task automatic rst_at(input int e);
        goto_edge(e);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got time %0t expected completion", $time);
        $fatal(1, "tb_timer_ctrl timeout");
    end

    initial begin
        int e0;
        rst     = 1'b1;
        iStart  = 1'b0;
        iStop   = 1'b0;
        iMode   = 1'b0;
        iPeriod = '0;
        iIrqAck = 1'b0;

        // Reset state.
        expect_at(0, 2, c_BUSY, 0);
        expect_at(0, 2, c_IRQ, 0);
        expect_at(0, 2, c_COUNT, 0);
        expect_at(0, 2, c_TICK, 0);
        expect_at(0, 4, c_BUSY, 0);
`ifdef TIMER_CTRL_OVERRUN_EN
        expect_at(0, 2, c_OVR, 0);
`endif
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // One-shot, period 3.
        e0 = cyc + 2;
        expect_at(1, e0, c_BUSY, 1);
        expect_at(1, e0, c_COUNT, 3);
        expect_at(1, e0, c_IRQ, 0);
        expect_at(1, e0, c_TICK, 0);
        expect_at(1, e0 + 3, c_TICK, 1);
        expect_at(1, e0 + 3, c_COUNT, 3);
        expect_at(1, e0 + 4, c_TICK, 0);
        expect_at(1, e0 + 4, c_COUNT, 2);
        expect_at(1, e0 + 7, c_TICK, 1);
        expect_at(1, e0 + 8, c_COUNT, 1);
        expect_at(1, e0 + 11, c_TICK, 1);
        expect_at(1, e0 + 11, c_COUNT, 1);
        expect_at(1, e0 + 11, c_IRQ, 0);
        expect_at(1, e0 + 12, c_COUNT, 0);
        expect_at(1, e0 + 12, c_IRQ, 1);
        expect_at(1, e0 + 12, c_BUSY, 0);
        expect_at(1, e0 + 12, c_TICK, 0);
        expect_at(1, e0 + 14, c_IRQ, 1);
        expect_at(1, e0 + 15, c_IRQ, 0);
        start_at(e0, 3, 1'b0);
        ack_at(e0 + 15);
        goto_edge(e0 + 18);

        // Periodic, period 2: expiries at +8, +16, +24 with acks in between.
        e0 = cyc + 2;
        expect_at(2, e0, c_BUSY, 1);
        expect_at(2, e0, c_COUNT, 2);
        expect_at(2, e0 + 4, c_COUNT, 1);
        expect_at(2, e0 + 7, c_COUNT, 1);
        expect_at(2, e0 + 7, c_IRQ, 0);
        expect_at(2, e0 + 8, c_COUNT, 2);
        expect_at(2, e0 + 8, c_IRQ, 1);
        expect_at(2, e0 + 8, c_BUSY, 1);
        expect_at(2, e0 + 9, c_IRQ, 1);
        expect_at(2, e0 + 10, c_IRQ, 0);
        expect_at(2, e0 + 12, c_COUNT, 1);
        expect_at(2, e0 + 15, c_IRQ, 0);
        expect_at(2, e0 + 16, c_IRQ, 1);
        expect_at(2, e0 + 16, c_COUNT, 2);
        expect_at(2, e0 + 16, c_BUSY, 1);
        expect_at(2, e0 + 23, c_IRQ, 0);
        expect_at(2, e0 + 24, c_IRQ, 1);
        expect_at(2, e0 + 24, c_COUNT, 2);
        expect_at(2, e0 + 24, c_BUSY, 1);
        expect_at(2, e0 + 26, c_BUSY, 0);
        expect_at(2, e0 + 26, c_COUNT, 0);
        expect_at(2, e0 + 26, c_IRQ, 1);
        expect_at(2, e0 + 28, c_IRQ, 0);
        start_at(e0, 2, 1'b1);
        ack_at(e0 + 10);
        ack_at(e0 + 18);
        stop_at(e0 + 26);
        ack_at(e0 + 28);
        goto_edge(e0 + 30);

        // Stop in the expiry cycle of a period-1 run.
        e0 = cyc + 2;
        expect_at(3, e0 + 3, c_BUSY, 1);
        expect_at(3, e0 + 3, c_COUNT, 1);
        expect_at(3, e0 + 3, c_TICK, 1);
        expect_at(3, e0 + 4, c_BUSY, 0);
        expect_at(3, e0 + 4, c_COUNT, 0);
        expect_at(3, e0 + 4, c_IRQ, 0);
        expect_at(3, e0 + 6, c_IRQ, 0);
        expect_at(3, e0 + 6, c_BUSY, 0);
        start_at(e0, 1, 1'b1);
        stop_at(e0 + 4);
        goto_edge(e0 + 8);

        // Restart with period 5 at +6 of a period-3 one-shot.
        e0 = cyc + 2;
        expect_at(4, e0 + 4, c_COUNT, 2);
        expect_at(4, e0 + 6, c_COUNT, 5);
        expect_at(4, e0 + 6, c_BUSY, 1);
        expect_at(4, e0 + 9, c_COUNT, 5);
        expect_at(4, e0 + 10, c_COUNT, 4);
        expect_at(4, e0 + 12, c_IRQ, 0);
        expect_at(4, e0 + 12, c_BUSY, 1);
        expect_at(4, e0 + 25, c_IRQ, 0);
        expect_at(4, e0 + 25, c_COUNT, 1);
        expect_at(4, e0 + 26, c_IRQ, 1);
        expect_at(4, e0 + 26, c_BUSY, 0);
        expect_at(4, e0 + 26, c_COUNT, 0);
        expect_at(4, e0 + 28, c_IRQ, 0);
        start_at(e0, 3, 1'b0);
        start_at(e0 + 6, 5, 1'b0);
        ack_at(e0 + 28);
        goto_edge(e0 + 30);

        // Ack colliding with a periodic expiry.
        e0 = cyc + 2;
        expect_at(5, e0 + 4, c_IRQ, 1);
        expect_at(5, e0 + 8, c_IRQ, 1);
        expect_at(5, e0 + 8, c_COUNT, 1);
        expect_at(5, e0 + 10, c_IRQ, 0);
        expect_at(5, e0 + 11, c_BUSY, 0);
        expect_at(5, e0 + 13, c_IRQ, 0);
`ifdef TIMER_CTRL_OVERRUN_EN
        expect_at(5, e0 + 4, c_OVR, 0);
        expect_at(5, e0 + 8, c_OVR, 1);
        expect_at(5, e0 + 10, c_OVR, 0);
`endif
        start_at(e0, 1, 1'b1);
        ack_at(e0 + 8);
        ack_at(e0 + 10);
        stop_at(e0 + 11);
        goto_edge(e0 + 15);

        // Reset mid-run, then a zero-period start that must be ignored.
        e0 = cyc + 2;
        expect_at(6, e0 + 4, c_IRQ, 1);
        expect_at(6, e0 + 5, c_BUSY, 1);
        expect_at(6, e0 + 6, c_BUSY, 0);
        expect_at(6, e0 + 6, c_IRQ, 0);
        expect_at(6, e0 + 6, c_COUNT, 0);
        expect_at(6, e0 + 6, c_TICK, 0);
`ifdef TIMER_CTRL_OVERRUN_EN
        expect_at(6, e0 + 6, c_OVR, 0);
`endif
        expect_at(6, e0 + 8, c_BUSY, 0);
        expect_at(6, e0 + 8, c_COUNT, 0);
        expect_at(6, e0 + 11, c_TICK, 0);
        expect_at(6, e0 + 12, c_BUSY, 0);
        expect_at(6, e0 + 12, c_IRQ, 0);
        start_at(e0, 1, 1'b1);
        rst_at(e0 + 6);
        start_at(e0 + 8, 0, 1'b1);
        goto_edge(e0 + 15);

        check_eq("scoreboard_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
